// File: rtl/aurora_rx_frame_buffer.sv
// Store-and-forward frame buffer behind the Aurora RX user interface: absorbs
// whole frames, optionally checks/strips the trailing sequence word, and
// releases only committed frames to a ready/valid consumer.
//
// Handshakes: the upstream side has no ready, so every word with
// s_axis_tvalid=1 is consumed on the clock edge where it is sampled. The
// downstream side transfers a word on every edge where m_axis_tvalid and
// m_axis_tready are both 1. While m_axis_tvalid=1, m_axis_tdata and
// m_axis_tlast hold until that transfer happens.
module aurora_rx_frame_buffer #(
  parameter int DEPTH_LOG2 = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  ctrl_strip_seq_en,
  output logic [15:0]           stat_frames_ok,
  output logic [15:0]           stat_frames_dropped,
  output logic [15:0]           stat_seq_err,
  output logic [DATA_WIDTH-1:0] stat_seq_last,
  output logic [1:0]            dbg_wr_state
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_DISCARD = 2'd2
  } wr_state_t;

  wr_state_t             r_state;
  wr_state_t             w_next_state;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_commit_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_strip;
  logic                  r_seq_base;
  logic [15:0]           r_frames_ok;
  logic [15:0]           r_frames_dropped;
  logic [15:0]           r_seq_err;
  logic [DATA_WIDTH-1:0] r_seq_last;

  logic [DATA_WIDTH-1:0] r_mem      [DEPTH];
  logic                  r_mem_last [DEPTH];

  logic [PW-1:0]         w_used;
  logic                  w_full;
  logic                  w_strip;
  logic                  w_payload_empty;
  logic [PW-1:0]         w_wr_ptr_nxt;
  logic [PW-1:0]         w_commit_ptr_nxt;
  logic                  w_mem_we;
  logic                  w_mem_wlast;
  logic                  w_set_last;
  logic                  w_commit;
  logic                  w_drop;
  logic                  w_seq_chk;
  logic                  w_rd_fire;
  logic [PW-1:0]         w_prev_ptr;
  logic [DEPTH_LOG2-1:0] w_wr_addr;
  logic [DEPTH_LOG2-1:0] w_prev_addr;
  logic [DEPTH_LOG2-1:0] w_rd_addr;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Occupancy counts uncommitted words too, so a frame in flight reserves space.
  assign w_used          = r_wr_ptr - r_rd_ptr;
  assign w_full          = (w_used == PW'(DEPTH));
  assign w_payload_empty = (r_wr_ptr == r_commit_ptr);
  assign w_strip         = (r_state == S_IDLE) ? ctrl_strip_seq_en : r_strip;
  assign w_prev_ptr      = r_wr_ptr - PW'(1);
  assign w_wr_addr       = r_wr_ptr[DEPTH_LOG2-1:0];
  assign w_prev_addr     = w_prev_ptr[DEPTH_LOG2-1:0];
  assign w_rd_addr       = r_rd_ptr[DEPTH_LOG2-1:0];

  assign m_axis_tvalid   = (r_rd_ptr != r_commit_ptr);
  assign m_axis_tdata    = m_axis_tvalid ? r_mem[w_rd_addr] : '0;
  assign m_axis_tlast    = m_axis_tvalid ? r_mem_last[w_rd_addr] : 1'b0;
  assign w_rd_fire       = m_axis_tvalid & m_axis_tready;

  assign stat_frames_ok      = r_frames_ok;
  assign stat_frames_dropped = r_frames_dropped;
  assign stat_seq_err        = r_seq_err;
  assign stat_seq_last       = r_seq_last;
  assign dbg_wr_state        = r_state;

  always_comb begin
    w_next_state     = r_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_commit_ptr_nxt = r_commit_ptr;
    w_mem_we         = 1'b0;
    w_mem_wlast      = 1'b0;
    w_set_last       = 1'b0;
    w_commit         = 1'b0;
    w_drop           = 1'b0;
    w_seq_chk        = 1'b0;
    if (s_axis_tvalid) begin
      case (r_state)
        S_IDLE, S_FILL: begin
          if (!s_axis_tlast) begin
            if (w_full) begin
              w_next_state = S_DISCARD;
            end else begin
              w_mem_we     = 1'b1;
              w_wr_ptr_nxt = r_wr_ptr + PW'(1);
              w_next_state = S_FILL;
            end
          end else begin
            w_next_state = S_IDLE;
            w_seq_chk    = w_strip;
            if (w_strip) begin
              // The sequence word is never stored; the last payload word gets the tlast bit.
              if (w_payload_empty) begin
                w_drop = 1'b1;
              end else begin
                w_set_last       = 1'b1;
                w_commit_ptr_nxt = r_wr_ptr;
                w_commit         = 1'b1;
              end
            end else if (w_full) begin
              w_drop       = 1'b1;
              w_wr_ptr_nxt = r_commit_ptr;
            end else begin
              w_mem_we         = 1'b1;
              w_mem_wlast      = 1'b1;
              w_wr_ptr_nxt     = r_wr_ptr + PW'(1);
              w_commit_ptr_nxt = r_wr_ptr + PW'(1);
              w_commit         = 1'b1;
            end
          end
        end
        S_DISCARD: begin
          if (s_axis_tlast) begin
            w_wr_ptr_nxt = r_commit_ptr;
            w_drop       = 1'b1;
            w_seq_chk    = r_strip;
            w_next_state = S_IDLE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_strip      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_ptr_nxt;
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (s_axis_tvalid && (r_state == S_IDLE)) begin
        r_strip <= ctrl_strip_seq_en;
      end
    end
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_frames_ok      <= '0;
      r_frames_dropped <= '0;
      r_seq_err        <= '0;
      r_seq_last       <= '0;
      r_seq_base       <= 1'b0;
    end else begin
      if (w_commit) begin
        r_frames_ok <= sat_inc(r_frames_ok);
      end
      if (w_drop) begin
        r_frames_dropped <= sat_inc(r_frames_dropped);
      end
      // The first checked frame after reset only establishes the baseline.
      if (w_seq_chk) begin
        if (r_seq_base && (s_axis_tdata != r_seq_last + DATA_WIDTH'(1))) begin
          r_seq_err <= sat_inc(r_seq_err);
        end
        r_seq_last <= s_axis_tdata;
        r_seq_base <= 1'b1;
      end
    end
  end

  // Storage needs no reset: only committed entries are ever presented.
  always_ff @(posedge m_axis_aclk) begin
    if (w_mem_we) begin
      r_mem[w_wr_addr]      <= s_axis_tdata;
      r_mem_last[w_wr_addr] <= w_mem_wlast;
    end
    if (w_set_last) begin
      r_mem_last[w_prev_addr] <= 1'b1;
    end
  end

endmodule

// File: doc/aurora_rx_frame_buffer.md
# aurora_rx_frame_buffer

Store-and-forward frame buffer directly downstream of the Aurora 8b10b RX user interface, in the `user_clk_out` domain. Aurora RX has no backpressure, so this block absorbs whole frames and releases only complete frames to the consumer through a ready/valid master. When enabled, it checks and strips the trailing sequence-number word. Frames that cannot fit are dropped whole and counted; partial frames are never emitted.

## Interface
- `DEPTH_LOG2`, 6: buffer capacity is 2^DEPTH_LOG2 words (64).
- `DATA_WIDTH`, 32: word width; also the sequence-number width.
- `m_axis_aclk`  in  1  sole clock (`user_clk_out`).
- `m_axis_aresetn`  in  1  reset, asynchronous assert, active-low; connect to `!sys_reset_out`.
- `s_axis_tvalid`  in  1  RX word valid; no tready, every valid word must be taken.
- `s_axis_tdata`  in  DATA_WIDTH  RX word.
- `s_axis_tlast`  in  1  last word of frame (sequence word when stripping).
- `m_axis_tvalid`  out  1  output word valid.
- `m_axis_tdata`  out  DATA_WIDTH  output word.
- `m_axis_tlast`  out  1  last payload word of frame.
- `m_axis_tready`  in  1  consumer ready.
- `ctrl_strip_seq_en`  in  1  strip and check the trailing sequence word.
- `stat_frames_ok`  out  16  committed frames, saturating.
- `stat_frames_dropped`  out  16  dropped frames (overflow or runt), saturating.
- `stat_seq_err`  out  16  sequence discontinuities, saturating.
- `stat_seq_last`  out  DATA_WIDTH  most recent received sequence word.

## Operation
- Storage: circular word array with a tlast bit per word. Pointers `wr_ptr`, `commit_ptr` and `rd_ptr` are each DEPTH_LOG2+1 bits. Used = `wr_ptr - rd_ptr`. Full when used == 2^DEPTH_LOG2.
- Write FSM states: IDLE, FILL, DISCARD.
  - IDLE: on the first valid word, latch `strip = ctrl_strip_seq_en` for the whole frame, then go to FILL. If that word has tlast, handle it as a 1-word frame.
  - FILL: each valid non-tlast word is written at `wr_ptr`, which then increments. A word arriving while full moves the FSM to DISCARD and is not written.
  - tlast in FILL, strip=0: write the word with tlast=1, then `commit_ptr <= wr_ptr+1`.
  - tlast in FILL, strip=1: do not store the word. Set the tlast bit at `wr_ptr-1` and set `commit_ptr <= wr_ptr`. A frame with zero payload words (seq word only) is a runt: it is dropped and counted in `stat_frames_dropped`.
  - tlast in FILL with strip=0 while full: the frame is dropped.
  - DISCARD: ignore words. On tlast, `wr_ptr <= commit_ptr`, increment `stat_frames_dropped`, go to IDLE.
- Any commit increments `stat_frames_ok`.
- Sequence check (strip=1 only): runs on the tlast word of every frame, including dropped and runt frames.
  - The first checked frame after reset only sets a baseline; no error is possible.
  - After that, if `seq != stat_seq_last + 1` (modulo 2^DATA_WIDTH, so 0xFFFFFFFF→0 is valid), increment `stat_seq_err`.
  - `stat_seq_last <= seq` always.
- Read side: `m_axis_tvalid = (rd_ptr != commit_ptr)`. tdata and tlast come from the entry at `rd_ptr`. On tvalid & tready, increment `rd_ptr`.
- A tlast-bit write at `wr_ptr-1` never targets a word visible to the reader, because that word is uncommitted.
- All counters saturate at 0xFFFF.

## Timing
- Reset (async, any time, including mid-frame):
  - All pointers 0, FSM IDLE, baseline flag clear.
  - `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`.
  - All `stat_*` = 0.
  - A partial frame in flight is lost. Words arriving after reset release before the next tlast are treated as a new frame.
- Latency: the tlast word is accepted at edge N, `commit_ptr` updates at edge N, and `m_axis_tvalid` is high after edge N (first payload word presented in cycle N+1).
- Throughput: one word in and one word out per cycle, concurrently. A commit and a read in the same cycle both take effect.
- Output stability: while tvalid=1 and tready=0, tdata and tlast hold.
- Full check: uses the `rd_ptr` registered at the current edge. A read in the same cycle does not free space for that cycle's write.
- Changes to `ctrl_strip_seq_en` mid-frame have no effect until the next frame.
- Status outputs are registered and update the edge after the triggering tlast.

## Test plan
- **Basic strip:** frame D0..D3 then seq=5, with strip=1 and tready=1 → out D0..D3, tlast on D3. Then frame seq=6 → `stat_frames_ok=2`, `stat_seq_err=0`, `stat_seq_last=6`.
- **Sequence gap and wrap:** seqs 0xFFFFFFFE, 0xFFFFFFFF, 0, 2 → `stat_seq_err=1` (only at 2). All 4 frames forwarded.
- **Overflow:** DEPTH_LOG2=6, tready=0.
  - Send a 40+1-word frame → committed.
  - Send another 40+1-word frame → dropped; `stat_frames_dropped=1`; seq of the dropped frame checked with no error.
  - Release tready → exactly 40 words out.
  - Next frame is accepted normally.
- **Runt and pass-through:** a lone tlast word with strip=1 → nothing output, dropped=1. With strip=0, a 3-word frame → all 3 words out, tlast on word 3, no seq check.
- **Backpressure:** toggle tready every cycle during output → no word lost or duplicated, data held while stalled. Simultaneous commit plus read gives correct ordering.
- **Mid-frame reset:** assert reset after 2 of 5 words → outputs and stats 0. Next full frame is forwarded correctly, with seq treated as baseline.
